// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and strobe sequencer for the external 1Mx16 SRAM
// Optional SRAM_ARB_ROUND_ROBIN_EN: ties go to the port that did not own the last access.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_write,
    input  logic [DATA_W-1:0] Data_read,
    output logic              tristate_output_enable
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_we_q, op_we_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                busy_q, busy_d;
    logic                ce_q, ce_d;
    logic                oe_q, oe_d;
    logic                wen_q, wen_d;
    logic                toe_q, toe_d;
    logic                pick1;
    logic                pick_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    assign pick1 = req1 & (~req0 | ~gnt_q);
`else
    assign pick1 = req1 & ~req0;
`endif
    assign pick_we = pick1 ? we1 : we0;

    // Strobes are computed from the next state so every SRAM pin comes straight off a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        ce_d    = ce_q;
        oe_d    = oe_q;
        wen_d   = wen_q;
        toe_d   = toe_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    gnt_d   = pick1;
                    addr_d  = pick1 ? addr1 : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    op_we_d = pick_we;
                    cnt_d   = CNT_LOAD;
                    ce_d    = 1'b0;
                    oe_d    = pick_we;
                    wen_d   = ~pick_we;
                    toe_d   = pick_we;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!op_we_q) begin
                        rdata_d = Data_read;
                    end
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    wen_d   = 1'b1;
                    toe_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ce_d    = 1'b1;
                oe_d    = 1'b1;
                wen_d   = 1'b1;
                toe_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_we_q <= 1'b0;
            gnt_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            toe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_we_q <= op_we_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            wen_q   <= wen_d;
            toe_q   <= toe_d;
        end
    end

    assign done0                  = done0_q;
    assign done1                  = done1_q;
    assign rdata                  = rdata_q;
    assign busy                   = busy_q;
    assign gnt                    = gnt_q;
    assign CE                     = ce_q;
    assign UB                     = ce_q;
    assign LB                     = ce_q;
    assign OE                     = oe_q;
    assign WE                     = wen_q;
    assign ADDR                   = addr_q;
    assign Data_write             = wdata_q;
    assign tristate_output_enable = toe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter (WAIT_CYCLES=2 main, WAIT_CYCLES=1 side instance)
module tb_sram_arbiter;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0, we0, req1, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        done0, done1, busy, gnt;
    logic [15:0] rdata, Data_write, Data_read;
    logic        CE, UB, LB, OE, WE, toe;
    logic [19:0] ADDR;

    logic        s_req0, s_we0, s_req1, s_we1;
    logic [19:0] s_addr0, s_addr1;
    logic [15:0] s_wdata0, s_wdata1;
    logic        s_done0, s_done1, s_busy, s_gnt;
    logic [15:0] s_rdata, s_Data_write, s_Data_read;
    logic        s_CE, s_UB, s_LB, s_OE, s_WE, s_toe;
    logic [19:0] s_ADDR;

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20), .DATA_W(16)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
        .rdata(rdata), .busy(busy), .gnt(gnt),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_write(Data_write), .Data_read(Data_read),
        .tristate_output_enable(toe)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20), .DATA_W(16)) u_dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .req0(s_req0), .we0(s_we0), .addr0(s_addr0), .wdata0(s_wdata0), .done0(s_done0),
        .req1(s_req1), .we1(s_we1), .addr1(s_addr1), .wdata1(s_wdata1), .done1(s_done1),
        .rdata(s_rdata), .busy(s_busy), .gnt(s_gnt),
        .CE(s_CE), .UB(s_UB), .LB(s_LB), .OE(s_OE), .WE(s_WE),
        .ADDR(s_ADDR), .Data_write(s_Data_write), .Data_read(s_Data_read),
        .tristate_output_enable(s_toe)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          b2b;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          first_ce = 0;
    int          last_done = 0;
    logic [15:0] model_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: strobe/bus checks every cycle, scoreboard pop on each done pulse.
    always @(negedge Clk) begin
        if (!Reset) begin
            acc_cnt = 0;
        end else begin
            chk("toe_only_in_access", {31'd0, toe & CE}, 32'd0);
            chk("ub_lb_follow_ce", {30'd0, UB, LB}, {30'd0, CE, CE});
            if (!CE) begin
                if (acc_cnt == 0) first_ce = cyc;
                acc_cnt++;
                if (sbq.size() > 0) begin
                    mon_e = sbq[0];
                    chk("acc_addr", {12'd0, ADDR}, {12'd0, mon_e.addr});
                    chk("acc_oe", {31'd0, OE}, {31'd0, mon_e.we});
                    chk("acc_we", {31'd0, WE}, {31'd0, ~mon_e.we});
                    chk("acc_toe", {31'd0, toe}, {31'd0, mon_e.we});
                    if (mon_e.we) chk("acc_wdata", {16'd0, Data_write}, {16'd0, mon_e.wdata});
                end
            end
            if (done0 || done1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_port", {30'd0, done1, done0}, mon_e.port ? 32'd2 : 32'd1);
                    chk("gnt", {31'd0, gnt}, {31'd0, mon_e.port});
                    chk("access_len", acc_cnt, W);
                    chk("access_to_done", cyc - first_ce, W);
                    chk("rdata", {16'd0, rdata}, {16'd0, mon_e.rdata});
                    chk("done_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1f);
                    chk("done_addr", {12'd0, ADDR}, {12'd0, mon_e.addr});
                    if (mon_e.b2b) chk("period", cyc - last_done, W + 2);
                end
                last_done = cyc;
                acc_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input bit port, input bit we, input logic [19:0] addr,
                        input logic [15:0] wdata, input logic [15:0] dread, input bit b2b);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        if (!we) model_rdata = dread;
        e.rdata = model_rdata;
        e.b2b   = b2b;
        sbq.push_back(e);
    endtask

    task automatic wait_done(input bit port, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (port ? done1 : done0) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_access(input bit port, input bit we, input logic [19:0] addr,
                             input logic [15:0] wdata, input logic [15:0] dread);
        int n;
        push(port, we, addr, wdata, dread, 1'b0);
        Data_read = dread;
        if (port) begin
            we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end
        wait_done(port, n);
        chk("req_to_done", n, W + 1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int          n;
        bit          order[4];
        logic [5:0]  ce_v, oe_v, dn_v;
        logic        d1_seen;

        Reset = 1'b0;
        {req0, we0, req1, we1} = 4'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; Data_read = '0;
        {s_req0, s_we0, s_req1, s_we1} = 4'b0;
        s_addr0 = '0; s_addr1 = '0; s_wdata0 = '0; s_wdata1 = '0; s_Data_read = '0;
        model_rdata = '0;
        tick();
        tick();
        chk("rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1f);
        chk("rst_toe_done_busy", {28'd0, toe, done0, done1, busy}, 32'd0);
        chk("rst_gnt", {31'd0, gnt}, 32'd1);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr_wdata", {ADDR, Data_write}, 36'd0);
        Reset = 1'b1;
        tick();

        // Continuous dual requests for four transactions.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++)
            push(order[i], 1'b0, order[i] ? 20'h00200 : 20'h00100, 16'h0, 16'hA5A5, i > 0);
        Data_read = 16'hA5A5;
        we0 = 1'b0; we1 = 1'b0; addr0 = 20'h00100; addr1 = 20'h00200;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 60 && sbq.size() > 0; i++) tick();
        chk("dual_drained", sbq.size(), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        do_access(1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF);
        tick();
        do_access(1'b1, 1'b1, 20'h00020, 16'h1234, 16'h5555);
        tick();

        // Address changes mid-access must not reach the SRAM.
        push(1'b0, 1'b0, 20'h00005, 16'h0, 16'h7777, 1'b0);
        Data_read = 16'h7777;
        we0 = 1'b0; addr0 = 20'h00005; req0 = 1'b1;
        tick();
        addr0 = 20'h00099;
        wait_done(1'b0, n);
        chk("req_to_done_addrchg", n + 1, W + 1);
        req0 = 1'b0;
        tick();

        // Reset in the second ACCESS cycle of a write.
        Data_read = 16'h6666;
        we1 = 1'b1; addr1 = 20'h00300; wdata1 = 16'hDEAD; req1 = 1'b1;
        tick();
        tick();
        chk("pre_reset_in_access", {30'd0, CE, WE}, 32'd0);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1f);
        chk("async_rst_toe_done_busy", {28'd0, toe, done0, done1, busy}, 32'd0);
        req1 = 1'b0;
        model_rdata = '0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        do_access(1'b1, 1'b0, 20'h00040, 16'h0000, 16'h4242);
        tick();

        // WAIT_CYCLES=1 instance: held request gives back-to-back accesses every 3 cycles.
        s_Data_read = 16'h1357;
        s_we0 = 1'b0; s_addr0 = 20'h00055; s_req0 = 1'b1;
        d1_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            ce_v[k] = s_CE;
            oe_v[k] = s_OE;
            dn_v[k] = s_done0;
            d1_seen = d1_seen | s_done1 | ~s_WE;
        end
        tick();
        s_req0 = 1'b0;
        chk("w1_ce_pattern", {26'd0, ce_v}, {26'd0, 6'b101101});
        chk("w1_oe_pattern", {26'd0, oe_v}, {26'd0, 6'b101101});
        chk("w1_done_pattern", {26'd0, dn_v}, {26'd0, 6'b100100});
        chk("w1_no_done1_no_we", {31'd0, d1_seen}, 32'd0);
        chk("w1_rdata", {16'd0, s_rdata}, 32'h1357);
        chk("w1_addr", {12'd0, s_ADDR}, 32'h00055);
        tick();
        tick();

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
